// File: rtl/icache_fetch_nway.sv
// icache_fetch_nway: N-way set-associative instruction cache with W-wide fetch.
// A hit delivers up to W leading instructions of one line (1-cycle latency),
// truncated at control flow, line end and intra-group RAW hazards. A miss runs
// a refill FSM over an AXI-style read channel into an invalid-first /
// round-robin victim way. Flush invalidates every line.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   fetch_en, flush, pc     fetch request, invalidate-all, slot-0 fetch PC
//   instr, fetch_cnt        W instruction slots (unused = 0), valid slot count
//   fetch_valid, miss       instr/fetch_cnt valid, refill in progress
//   ar_valid/ar_ready/ar_addr   refill read-address handshake
//   r_valid/r_data/r_last   refill read-data beats
module icache_fetch_nway #(
  parameter int unsigned N = 2,
  parameter int unsigned S = 64,
  parameter int unsigned B = 64,
  parameter int unsigned W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic [63:0]              pc,
  output logic [32*W-1:0]          instr,
  output logic [$clog2(W+1)-1:0]   fetch_cnt,
  output logic                     fetch_valid,
  output logic                     miss,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [63:0]              ar_addr,
  input  logic                     r_valid,
  input  logic [63:0]              r_data,
  input  logic                     r_last
);

  localparam int unsigned NW  = $clog2(N);
  localparam int unsigned SW  = $clog2(S);
  localparam int unsigned BW  = $clog2(B);
  localparam int unsigned TW  = 64 - SW - BW;
  localparam int unsigned IW  = BW - 2;   // instruction index within a line
  localparam int unsigned BCW = BW - 3;   // 64-bit beat index within a line
  localparam int unsigned LW  = SW + NW;  // line index {set, way}
  localparam int unsigned CW  = $clog2(W + 1);
  localparam int unsigned NL  = S * N;
  localparam int unsigned BPL = B / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Storage
  logic [63:0]          data_q [NL][BPL];
  logic [TW-1:0]        tag_q  [NL];
  logic [NL-1:0]        valid_q, valid_d;
  logic [S-1:0][NW-1:0] rr_q, rr_d;

  // Refill control
  logic [1:0]     state_q, state_d;
  logic           drop_q, drop_d;
  logic           from_rr_q, from_rr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [LW-1:0]  mline_q, mline_d;
  logic [TW-1:0]  mtag_q, mtag_d;
  logic           data_we, tag_we;

  // Next values of the registered outputs
  logic [32*W-1:0] instr_d;
  logic [CW-1:0]   cnt_d;
  logic            fetch_valid_d, miss_d, ar_valid_d;
  logic [63:0]     ar_addr_d;

  // Address split
  logic [SW-1:0] set_idx;
  logic [TW-1:0] pc_tag;
  logic [IW-1:0] widx;
  logic          unused_pc;
  assign set_idx   = pc[BW +: SW];
  assign pc_tag    = pc[63 -: TW];
  assign widx      = pc[BW-1:2];
  assign unused_pc = ^pc[1:0];

  function automatic logic is_ctrl(input logic [6:0] op);
    return op inside {7'b0000000, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};
  endfunction

  function automatic logic is_writer(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b0010111,
                      7'b0110111, 7'b0110011, 7'b0111011};
  endfunction

  // True when ins reads a register present in the written-register mask.
  function automatic logic raw_hazard(input logic [31:0] ins, input logic [31:0] wmask);
    logic r1, r2;
    r2 = ins[6:0] inside {7'b0100011, 7'b0110011, 7'b0111011, 7'b1100011};
    r1 = r2 || (ins[6:0] inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111});
    return (r1 && wmask[ins[19:15]]) || (r2 && wmask[ins[24:20]]);
  endfunction

  // Tag lookup; lowest matching way wins
  logic          hit;
  logic [LW-1:0] hit_line;
  always_comb begin
    hit      = 1'b0;
    hit_line = {set_idx, NW'(0)};
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid_q[{set_idx, NW'(i)}] && (tag_q[{set_idx, NW'(i)}] == pc_tag)) begin
        hit      = 1'b1;
        hit_line = {set_idx, NW'(i)};
      end
    end
  end

  // Victim: lowest invalid way, else the set's round-robin pointer
  logic [NW-1:0] victim;
  logic          victim_rr;
  always_comb begin
    victim    = rr_q[set_idx];
    victim_rr = 1'b1;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!valid_q[{set_idx, NW'(i)}]) begin
        victim    = NW'(i);
        victim_rr = 1'b0;
      end
    end
  end

  // Slot extraction and truncation from the hit line
  logic [32*W-1:0] slot_instr;
  logic [CW-1:0]   slot_cnt;
  logic [31:0]     wr_mask;
  logic [31:0]     ins, prev;
  logic [IW:0]     pos;
  logic [63:0]     word;
  logic            ok, prev_ok;
  always_comb begin
    slot_instr = '0;
    slot_cnt   = '0;
    wr_mask    = '0;
    ins        = '0;
    prev       = '0;
    pos        = '0;
    word       = '0;
    ok         = 1'b0;
    prev_ok    = 1'b1;
    for (int k = 0; k < int'(W); k++) begin
      pos  = {1'b0, widx} + (IW+1)'(k);
      word = data_q[hit_line][pos[IW-1:1]];
      ins  = pos[0] ? word[63:32] : word[31:0];
      // pos[IW] set means the slot spilled past the end of the line
      ok   = (k == 0) || (prev_ok && !pos[IW] && !is_ctrl(prev[6:0]) && !raw_hazard(ins, wr_mask));
      if (ok) begin
        slot_instr[32*k +: 32] = ins;
        slot_cnt = slot_cnt + CW'(1);
        if (is_writer(ins[6:0]) && (ins[11:7] != 5'd0)) begin
          wr_mask[ins[11:7]] = 1'b1;
        end
      end
      prev_ok = ok;
      prev    = ins;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    rr_d          = rr_q;
    drop_d        = drop_q;
    from_rr_d     = from_rr_q;
    beat_d        = beat_q;
    mline_d       = mline_q;
    mtag_d        = mtag_q;
    instr_d       = instr;
    cnt_d         = fetch_cnt;
    fetch_valid_d = 1'b0;
    miss_d        = miss;
    ar_valid_d    = ar_valid;
    ar_addr_d     = ar_addr;
    data_we       = 1'b0;
    tag_we        = 1'b0;

    // A flush during a refill lets the bus transfer finish but never validates the line
    if (flush) begin
      valid_d = '0;
      if (state_q != ST_IDLE) drop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!flush && fetch_en) begin
          if (hit) begin
            fetch_valid_d = 1'b1;
            instr_d       = slot_instr;
            cnt_d         = slot_cnt;
          end else begin
            state_d    = ST_REQ;
            miss_d     = 1'b1;
            ar_valid_d = 1'b1;
            ar_addr_d  = {pc[63:BW], BW'(0)};
            mline_d    = {set_idx, victim};
            mtag_d     = pc_tag;
            from_rr_d  = victim_rr;
            drop_d     = 1'b0;
            beat_d     = '0;
          end
        end
      end
      ST_REQ: begin
        if (ar_ready) begin
          state_d    = ST_FILL;
          ar_valid_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (r_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + BCW'(1);
          if (r_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        tag_we = 1'b1;
        if (!drop_q && !flush) valid_d[mline_q] = 1'b1;
        if (from_rr_q) rr_d[mline_q[LW-1 -: SW]] = rr_q[mline_q[LW-1 -: SW]] + NW'(1);
        miss_d  = 1'b0;
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      rr_q        <= '0;
      drop_q      <= 1'b0;
      from_rr_q   <= 1'b0;
      beat_q      <= '0;
      mline_q     <= '0;
      mtag_q      <= '0;
      instr       <= '0;
      fetch_cnt   <= '0;
      fetch_valid <= 1'b0;
      miss        <= 1'b0;
      ar_valid    <= 1'b0;
      ar_addr     <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      drop_q      <= drop_d;
      from_rr_q   <= from_rr_d;
      beat_q      <= beat_d;
      mline_q     <= mline_d;
      mtag_q      <= mtag_d;
      instr       <= instr_d;
      fetch_cnt   <= cnt_d;
      fetch_valid <= fetch_valid_d;
      miss        <= miss_d;
      ar_valid    <= ar_valid_d;
      ar_addr     <= ar_addr_d;
    end
  end

  // Line data and tag arrays; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (data_we) data_q[mline_q][beat_q] <= r_data;
    if (tag_we)  tag_q[mline_q]          <= mtag_q;
  end

endmodule

// File: tb/tb_icache_fetch_nway.sv
// Self-checking bench for icache_fetch_nway (N=4, S=64, B=64, W=2).
module tb_icache_fetch_nway;
  localparam int N = 4;
  localparam int S = 64;
  localparam int B = 64;
  localparam int W = 2;

  logic            clk = 1'b0;
  logic            reset, fetch_en, flush, ar_ready, r_valid, r_last;
  logic [63:0]     pc, r_data, ar_addr;
  logic [32*W-1:0] instr;
  logic [1:0]      fetch_cnt;
  logic            fetch_valid, miss, ar_valid;

  always #5 clk = ~clk;

  icache_fetch_nway #(.N(N), .S(S), .B(B), .W(W)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .flush(flush), .pc(pc),
    .instr(instr), .fetch_cnt(fetch_cnt), .fetch_valid(fetch_valid), .miss(miss),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_data(r_data), .r_last(r_last)
  );

  int errors = 0;
  int checks = 0;

  // Backing memory (word address -> instruction) and reference cache state
  logic [31:0] imem [logic [63:0]];
  logic [63:0] m_line  [S][N];
  bit          m_valid [S][N];
  int          m_rr    [S];

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 11))
      0: op = 7'b0010011;  1: op = 7'b0110011;  2: op = 7'b0000011;  3: op = 7'b0100011;
      4: op = 7'b1100011;  5: op = 7'b1101111;  6: op = 7'b1100111;  7: op = 7'b0110111;
      8: op = 7'b0010111;  9: op = 7'b0011011; 10: op = 7'b0111011; default: op = 7'b1110011;
    endcase
    return {7'($urandom), 2'b00, 3'($urandom), 2'b00, 3'($urandom), 3'($urandom),
            2'b00, 3'($urandom), op};
  endfunction

  function automatic logic [31:0] get_word(input logic [63:0] a);
    if (!imem.exists(a)) imem[a] = rand_instr();
    return imem[a];
  endfunction

  function automatic int m_set(input logic [63:0] a);
    return int'((a / 64'(B)) % 64'(S));
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < S; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < N; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < N; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic int m_lookup(input logic [63:0] a);
    int s = m_set(a);
    for (int w = 0; w < N; w++)
      if (m_valid[s][w] && m_line[s][w] == a / 64'(B)) return w;
    return -1;
  endfunction

  // Invalid-first, otherwise round-robin pointer (which then advances)
  function automatic int m_alloc(input logic [63:0] a);
    int s = m_set(a);
    int v = -1;
    for (int w = 0; w < N; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % N;
    end
    return v;
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == 7'b0100011 || op == 7'b0110011 || op == 7'b0111011 || op == 7'b1100011;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return reads_rs2(op) || op == 7'b0000011 || op == 7'b0010011 ||
           op == 7'b0011011 || op == 7'b1100111;
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0010011 || op == 7'b0011011 || op == 7'b0010111 ||
           op == 7'b0110111 || op == 7'b0110011 || op == 7'b0111011;
  endfunction

  function automatic bit stops_group(input logic [6:0] op);
    return op == 7'b0000000 || op == 7'b1100011 || op == 7'b1100111 ||
           op == 7'b1101111 || op == 7'b1110011;
  endfunction

  // Expected fetch group for a PC: walk addresses, stop at the first rule violation
  function automatic void model_slots(input logic [63:0] a, output int cnt,
                                      output logic [32*W-1:0] iv);
    bit [31:0]   written;
    logic [31:0] w, pw;
    logic [63:0] ak;
    written = '0;
    pw = '0;
    cnt = 0;
    iv = '0;
    for (int k = 0; k < W; k++) begin
      ak = a + 64'(4 * k);
      if (k > 0) begin
        if (ak / 64'(B) != a / 64'(B)) break;
        if (stops_group(pw[6:0])) break;
      end
      w = get_word(ak);
      if (k > 0) begin
        if (reads_rs1(w[6:0]) && written[w[19:15]]) break;
        if (reads_rs2(w[6:0]) && written[w[24:20]]) break;
      end
      iv[32*k +: 32] = w;
      cnt++;
      if (writes_rd(w[6:0]) && w[11:7] != 5'd0) written[w[11:7]] = 1'b1;
      pw = w;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b0; r_last = 1'b0; r_data = '0; pc = '0;
    @(negedge clk);
    checks++;
    if (instr !== '0 || fetch_cnt !== 2'd0 || fetch_valid !== 1'b0 || miss !== 1'b0 ||
        ar_valid !== 1'b0 || ar_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got instr=%h cnt=%0d fv=%b miss=%b arv=%b ar_addr=%h, want all zero",
               instr, fetch_cnt, fetch_valid, miss, ar_valid, ar_addr);
    end
    reset = 1'b0;
    m_reset();
  endtask

  // One fetch of PC a: hit check, or full miss/refill sequence with optional
  // AR stall, flush at beat flush_beat, or reset at beat reset_beat.
  task automatic do_fetch(input logic [63:0] a, input int stall, input int flush_beat,
                          input int reset_beat, output int got_cnt,
                          output logic [32*W-1:0] got_iv, output bit was_hit);
    int              exp_cnt, s, v;
    logic [32*W-1:0] exp_iv;
    logic [63:0]     line;
    bit              drop;
    line = a & ~64'(B - 1);
    got_cnt = -1;
    got_iv = '0;
    @(negedge clk);
    fetch_en = 1'b1; pc = a; flush = 1'b0;
    @(negedge clk);
    was_hit = (m_lookup(a) >= 0);
    if (was_hit) begin
      model_slots(a, exp_cnt, exp_iv);
      got_cnt = int'(fetch_cnt);
      got_iv = instr;
      checks++;
      if (fetch_valid !== 1'b1 || miss !== 1'b0) begin
        errors++;
        $display("FAIL hit_flags pc=%h: got fv=%b miss=%b, want fv=1 miss=0", a, fetch_valid, miss);
      end
      checks++;
      if (fetch_cnt !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL hit_cnt pc=%h: got %0d, want %0d", a, fetch_cnt, exp_cnt);
      end
      checks++;
      if (instr !== exp_iv) begin
        errors++;
        $display("FAIL hit_instr pc=%h: got %h, want %h", a, instr, exp_iv);
      end
      fetch_en = 1'b0;
      return;
    end
    // Miss path
    s = m_set(a);
    v = m_alloc(a);
    checks++;
    if (miss !== 1'b1 || ar_valid !== 1'b1 || fetch_valid !== 1'b0 || ar_addr !== line) begin
      errors++;
      $display("FAIL miss_start pc=%h: got miss=%b arv=%b fv=%b ar_addr=%h, want 1 1 0 %h",
               a, miss, ar_valid, fetch_valid, ar_addr, line);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (ar_valid !== 1'b1 || ar_addr !== line) begin
        errors++;
        $display("FAIL ar_hold pc=%h cyc=%0d: got arv=%b ar_addr=%h, want 1 %h",
                 a, i, ar_valid, ar_addr, line);
      end
    end
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    checks++;
    if (ar_valid !== 1'b0 || miss !== 1'b1) begin
      errors++;
      $display("FAIL ar_accept pc=%h: got arv=%b miss=%b, want 0 1", a, ar_valid, miss);
    end
    drop = 1'b0;
    for (int i = 0; i < B / 8; i++) begin
      if (i == reset_beat) begin
        r_valid = 1'b0; r_last = 1'b0; reset = 1'b1; fetch_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (miss !== 1'b0 || ar_valid !== 1'b0 || fetch_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_fill pc=%h: got miss=%b arv=%b fv=%b, want 0 0 0",
                   a, miss, ar_valid, fetch_valid);
        end
        m_reset();
        return;
      end
      r_valid = 1'b1;
      r_data = {get_word(line + 64'(8 * i + 4)), get_word(line + 64'(8 * i))};
      r_last = (i == B / 8 - 1);
      if (i == flush_beat) begin
        flush = 1'b1;
        drop = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
    end
    r_valid = 1'b0; r_last = 1'b0;
    if (drop) m_flush();
    else begin
      m_valid[s][v] = 1'b1;
      m_line[s][v] = a / 64'(B);
    end
    checks++;
    if (miss !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_cycle pc=%h: got miss=%b fv=%b, want 1 0", a, miss, fetch_valid);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_drop pc=%h: got miss=%b fv=%b, want 0 0", a, miss, fetch_valid);
    end
    if (drop) begin
      fetch_en = 1'b0;
      return;
    end
    @(negedge clk);
    model_slots(a, exp_cnt, exp_iv);
    got_cnt = int'(fetch_cnt);
    got_iv = instr;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_cnt !== 2'(exp_cnt) || instr !== exp_iv) begin
      errors++;
      $display("FAIL refetch_hit pc=%h: got fv=%b cnt=%0d instr=%h, want 1 %0d %h",
               a, fetch_valid, fetch_cnt, instr, exp_cnt, exp_iv);
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_cold_miss();
    int c; logic [63:0] iv; bit h;
    do_reset();
    imem[64'h1000] = {12'd1, 5'd0, 3'd0, 5'd1, 7'h13};           // addi x1,x0,1
    imem[64'h1004] = {12'd2, 5'd3, 3'd0, 5'd2, 7'h13};           // addi x2,x3,2
    imem[64'h1010] = {12'd1, 5'd1, 3'd0, 5'd5, 7'h13};           // addi x5,x1,1
    imem[64'h1014] = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};      // add  x6,x5,x2
    imem[64'h1020] = {12'd1, 5'd1, 3'd0, 5'd0, 7'h13};           // addi x0,x1,1
    imem[64'h1024] = {7'd0, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33};      // add  x6,x0,x2
    imem[64'h1030] = {20'h00800, 5'd1, 7'h6F};                   // jal  x1,8
    imem[64'h1034] = {12'd0, 5'd0, 3'd0, 5'd7, 7'h13};           // addi x7,x0,0
    imem[64'h103C] = {12'd1, 5'd0, 3'd0, 5'd8, 7'h13};           // addi x8,x0,1
    do_fetch(64'h1000, 3, -1, -1, c, iv, h);
    checks++;
    if (h !== 1'b0 || c != 2) begin
      errors++;
      $display("FAIL cold_fetch: got hit=%b cnt=%0d, want hit=0 cnt=2", h, c);
    end
  endtask

  task automatic test_slot_rules();
    int c; logic [63:0] iv; bit h;
    do_fetch(64'h1010, 0, -1, -1, c, iv, h);
    checks++;
    if (c != 1 || iv[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL raw_trunc: got cnt=%0d slot1=%h, want cnt=1 slot1=0", c, iv[63:32]);
    end
    // Idle cycle: fetch_valid drops, instr/fetch_cnt hold
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0 || fetch_cnt !== 2'd1 || instr[31:0] !== imem[64'h1010]) begin
      errors++;
      $display("FAIL idle_hold: got fv=%b cnt=%0d slot0=%h, want 0 1 %h",
               fetch_valid, fetch_cnt, instr[31:0], imem[64'h1010]);
    end
    do_fetch(64'h1020, 0, -1, -1, c, iv, h);
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL x0_no_raw: got cnt=%0d, want 2", c);
    end
    do_fetch(64'h1030, 0, -1, -1, c, iv, h);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL jal_trunc: got cnt=%0d, want 1", c);
    end
    do_fetch(64'h103C, 0, -1, -1, c, iv, h);
    checks++;
    if (c != 1 || h !== 1'b1) begin
      errors++;
      $display("FAIL line_end: got cnt=%0d hit=%b, want cnt=1 hit=1", c, h);
    end
  endtask

  task automatic test_replacement();
    int c; logic [63:0] iv; bit h;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      do_fetch(64'h10_0000 + 64'(t * 'h1000), t % 3, -1, -1, c, iv, h);
      checks++;
      if (h !== 1'b0) begin
        errors++;
        $display("FAIL repl_fill t=%0d: got hit=%b, want 0", t, h);
      end
    end
    for (int t = 2; t < 6; t++) begin
      do_fetch(64'h10_0000 + 64'(t * 'h1000), 0, -1, -1, c, iv, h);
      checks++;
      if (h !== 1'b1) begin
        errors++;
        $display("FAIL repl_keep t=%0d: got hit=%b, want 1", t, h);
      end
    end
    do_fetch(64'h10_1000, 0, -1, -1, c, iv, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL repl_evicted t=1: got hit=%b, want 0", h);
    end
  endtask

  task automatic test_flush_fill();
    int c; logic [63:0] iv; bit h;
    do_reset();
    do_fetch(64'h3000, 1, 2, -1, c, iv, h);
    do_fetch(64'h3000, 0, -1, -1, c, iv, h);
    checks++;
    if (h !== 1'b0 || c != int'(fetch_cnt)) begin
      errors++;
      $display("FAIL flush_fill_refetch: got hit=%b, want 0", h);
    end
  endtask

  task automatic test_flush_idle();
    int c; logic [63:0] iv; bit h;
    do_reset();
    do_fetch(64'h2008, 0, -1, -1, c, iv, h);
    @(negedge clk);
    fetch_en = 1'b1; flush = 1'b1; pc = 64'h2008;
    @(negedge clk);
    fetch_en = 1'b0; flush = 1'b0;
    m_flush();
    checks++;
    if (fetch_valid !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got fv=%b miss=%b, want 0 0", fetch_valid, miss);
    end
    do_fetch(64'h2008, 0, -1, -1, c, iv, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_refetch: got hit=%b, want 0", h);
    end
  endtask

  task automatic test_reset_mid_fill();
    int c; logic [63:0] iv; bit h;
    do_reset();
    do_fetch(64'h4000, 0, -1, 3, c, iv, h);
    do_fetch(64'h4000, 0, -1, -1, c, iv, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill_refetch: got hit=%b, want 0", h);
    end
  endtask

  task automatic test_random();
    int c; logic [63:0] iv; bit h;
    logic [63:0] a;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      a = 64'h20_0000 + 64'($urandom_range(0, 5) * 'h1000) +
          64'($urandom_range(0, 2) * B) + 64'($urandom_range(0, B / 4 - 1) * 4);
      do_fetch(a, int'($urandom_range(0, 2)), -1, -1, c, iv, h);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; pc = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
    m_reset();
    test_reset();
    test_cold_miss();
    test_slot_rules();
    test_replacement();
    test_flush_fill();
    test_flush_idle();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
